// File: rtl/mul_if.sv
// Request/result bundle between the datapath control and the iterative multiplier.
interface mul_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic [1:0]       flags;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, flags
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, flags
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for MUL/UMULL/SMULL, one multiplier bit per cycle.
// Optional EARLY_TERM_EN: leave CALC as soon as the remaining multiplier is zero.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  mul_if.slave  bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state_q,  state_d;
  logic             long_q,   long_d;
  logic             sign_q,   sign_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q,    acc_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [1:0]       flags_q,  flags_d;
  logic             done_q,   done_d;

  logic             is_smull;
  logic             last_step;
  logic [PW-1:0]    product;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      long_q   <= 1'b0;
      sign_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      long_q   <= long_d;
      sign_q   <= sign_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    long_d    = long_q;
    sign_d    = sign_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    is_smull  = (bus.op == 2'b10);
    last_step = 1'b0;
    product   = sign_q ? (~acc_q + PW'(1)) : acc_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = CALC;
          long_d   = (bus.op == 2'b01) || is_smull;
          sign_d   = is_smull && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          // Magnitudes are unsigned, so |most-negative| stays representable.
          mcand_d  = (is_smull && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
          mplier_d = (is_smull && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
          acc_d    = '0;
          count_d  = '0;
        end
      end
      CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << count_q);
        end
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
`ifdef EARLY_TERM_EN
        last_step = (mplier_d == '0) || (count_q == CW'(WIDTH - 1));
`else
        last_step = (count_q == CW'(WIDTH - 1));
`endif
        if (last_step) begin
          state_d = FIN;
        end
      end
      FIN: begin
        if (long_q) begin
          hi_d    = product[PW-1:WIDTH];
          lo_d    = product[WIDTH-1:0];
          flags_d = {product[PW-1], (product == '0)};
        end else begin
          hi_d    = '0;
          lo_d    = product[WIDTH-1:0];
          flags_d = {product[WIDTH-1], (product[WIDTH-1:0] == '0)};
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q == CALC) || (state_q == FIN);
  assign bus.done      = done_q;
  assign bus.result_lo = lo_q;
  assign bus.result_hi = hi_q;
  assign bus.flags     = flags_q;
endmodule
